// File: rtl/branch_pred_pcsel.sv
// Bimodal branch predictor with priority PC-select and flush; table init sweeps 2**IDX_W cycles after rst.
// Optional BP_STATS_EN macro builds resolved-branch / mispredict counters; otherwise the stat outputs read 0.
module branch_pred_pcsel #(
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_is_branch,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic [6:0]      res_opcode,
  input  logic [2:0]      res_funct3,
  input  logic            res_pred_taken,
  input  logic            BrEq,
  input  logic            BrLt,
  input  logic            is_jal_id,
  input  logic            stall,
  output logic [2:0]      PCSel,
  output logic            flush,
  output logic            bp_ready,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int         DEPTH   = 1 << IDX_W;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [1:0]       r_bht [DEPTH];

  logic             w_run;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic [1:0]       w_if_ctr;
  logic [1:0]       w_res_ctr;
  logic [1:0]       w_ctr_next;
  logic             w_is_br;
  logic             w_is_jalr;
  logic             w_taken;
  logic             w_mispred;
  logic             w_upd;
  logic             w_unused;

  assign w_unused  = ^{if_pc, res_pc};
  assign w_run     = (r_state == ST_RUN);
  assign w_if_idx  = if_pc[IDX_W+1:2];
  assign w_res_idx = res_pc[IDX_W+1:2];
  assign w_if_ctr  = r_bht[w_if_idx];
  assign w_res_ctr = r_bht[w_res_idx];

  assign pred_taken = w_run & if_valid & if_is_branch & w_if_ctr[1];
  assign bp_ready   = w_run;

  // funct3 010/011 are not legal branch encodings and never count as branches
  assign w_is_br   = (res_opcode == OP_BR) && (res_funct3[2:1] != 2'b01);
  assign w_is_jalr = res_valid && (res_opcode == OP_JALR);

  always_comb begin
    w_taken = 1'b0;
    case (res_funct3)
      3'b000:          w_taken = BrEq;
      3'b001:          w_taken = ~BrEq;
      3'b100, 3'b110:  w_taken = BrLt;
      3'b101, 3'b111:  w_taken = ~BrLt;
      default:         w_taken = 1'b0;
    endcase
  end

  assign w_mispred = res_valid & w_is_br & (w_taken != res_pred_taken);
  assign w_upd     = w_run & res_valid & w_is_br & ~stall;
  assign flush     = w_mispred | w_is_jalr;

  always_comb begin
    PCSel = 3'd0;
    if (w_mispred && w_taken)       PCSel = 3'd2;
    else if (w_mispred)             PCSel = 3'd4;
    else if (w_is_jalr)             PCSel = 3'd2;
    else if (is_jal_id)             PCSel = 3'd1;
    else if (pred_taken)            PCSel = 3'd3;
  end

  always_comb begin
    w_ctr_next = w_res_ctr;
    if (w_taken && w_res_ctr != 2'b11)       w_ctr_next = w_res_ctr + 2'd1;
    else if (!w_taken && w_res_ctr != 2'b00) w_ctr_next = w_res_ctr - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else if (r_state == ST_INIT) begin
      r_ptr <= r_ptr + IDX_W'(1);
      if (r_ptr == {IDX_W{1'b1}}) r_state <= ST_RUN;
    end
  end

  // Table has no reset of its own; the INIT sweep is what clears it
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_bht[r_ptr] <= CTR_INIT;
    else if (w_upd)         r_bht[w_res_idx] <= w_ctr_next;
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (w_upd) begin
      r_stat_br <= r_stat_br + 32'd1;
      if (w_mispred) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_mispred  = r_stat_mis;
`else
  assign stat_branches = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule
